// File: rtl/mem_byte_pkg.sv
// Shared types for the byte-wide memory initiator: FSM states, lane index, helpers.
package mem_byte_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef logic [1:0] lane_t;

   // Lane position fed to next_lane_sel; all-ones stands for "before lane 0".
   localparam logic [2:0] LANE_NONE = 3'b111;

   function automatic logic [2:0] lane_pos(input lane_t l);
      return {1'b0, l};
   endfunction

   // Bit offset of a lane's byte inside the 32-bit word.
   function automatic logic [4:0] lane_lsb(input lane_t l);
      return {l, 3'b000};
   endfunction

endpackage

// File: rtl/next_lane_sel.sv
// Finds the lowest enabled lane strictly above cur; cur = LANE_NONE picks the first lane.
module next_lane_sel
   import mem_byte_pkg::*;
(
   input  logic [LANES-1:0] be,
   input  logic [2:0]       cur,
   output lane_t            next_lane_c,
   output logic             none_left_c
);

   logic [2:0] floor_c;

   always_comb begin
      next_lane_c = '0;
      none_left_c = 1'b1;
      floor_c     = cur + 3'd1;
      // Scan downward so the lowest eligible lane wins.
      for (int i = LANES - 1; i >= 0; i--) begin
         if (be[i] && (3'(i) >= floor_c)) begin
            next_lane_c = lane_t'(i);
            none_left_c = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_byte_initiator.sv
// Splits a 32-bit core load/store into sequential byte accesses on a byte-wide memory port.
// Optional per-byte response timeout: define MEM_BYTE_INITIATOR_TIMEOUT_EN.
module mem_byte_initiator
   import mem_byte_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [3:0]            req_be,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   state_t                  state_q, state_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [WORD_W-1:0]       wdata_q, wdata_d;
   logic [LANES-1:0]        be_q, be_d;
   lane_t                   lane_q, lane_d;

   logic                    req_ready_q, req_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;
   logic                    mem_read_q, mem_read_d;
   logic                    mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

   logic [LANES-1:0]        sel_be_c;
   logic [2:0]              sel_cur_c;
   lane_t                   sel_lane_c;
   logic                    sel_none_c;

`ifdef MEM_BYTE_INITIATOR_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
   logic                    timed_out_c;
   assign timed_out_c = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
   logic                    timeout_unused;
   assign timeout_unused = (TIMEOUT == 0);
`endif

   // In IDLE the finder picks the first lane of the incoming request.
   assign sel_be_c  = (state_q == IDLE) ? req_be    : be_q;
   assign sel_cur_c = (state_q == IDLE) ? LANE_NONE : lane_pos(lane_q);

   next_lane_sel u_next_lane_sel (
      .be          (sel_be_c),
      .cur         (sel_cur_c),
      .next_lane_c (sel_lane_c),
      .none_left_c (sel_none_c)
   );

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      lane_d      = lane_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef MEM_BYTE_INITIATOR_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               write_d     = req_write;
               base_d      = req_addr;
               wdata_d     = req_wdata;
               be_d        = req_be;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
`ifdef MEM_BYTE_INITIATOR_TIMEOUT_EN
               wait_cnt_d  = '0;
`endif
               if (sel_none_c) begin
                  state_d = DONE;
               end else begin
                  state_d = ACCESS;
                  lane_d  = sel_lane_c;
               end
            end
         end
         ACCESS: begin
            if (mem_resp) begin
               if (!write_q) begin
                  rsp_rdata_d[lane_lsb(lane_q) +: BYTE_W] = BYTE_W'(mem_rdata);
               end
`ifdef MEM_BYTE_INITIATOR_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
               if (sel_none_c) begin
                  state_d = DONE;
               end else begin
                  lane_d = sel_lane_c;
               end
            end
`ifdef MEM_BYTE_INITIATOR_TIMEOUT_EN
            else if (timed_out_c) begin
               state_d   = DONE;
               rsp_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next-state view so they line up with the state.
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == DONE);
      mem_read_d  = (state_d == ACCESS) && !write_d;
      mem_write_d = (state_d == ACCESS) &&  write_d;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if (state_d == ACCESS) begin
         mem_addr_d  = base_d + ADDR_WIDTH'(lane_d);
         mem_wdata_d = DATA_WIDTH'(wdata_d[lane_lsb(lane_d) +: BYTE_W]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         base_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         lane_q      <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef MEM_BYTE_INITIATOR_TIMEOUT_EN
         wait_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         lane_q      <= lane_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef MEM_BYTE_INITIATOR_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Self-checking bench for mem_byte_initiator against a byte-memory reference model.
module tb_mem_byte_initiator;

   localparam int unsigned AW      = 32;
   localparam int unsigned TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_be;
   logic          rsp_valid, rsp_err;
   logic [31:0]   rsp_rdata;
   logic          mem_read, mem_write, mem_resp;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata, mem_rdata;

   logic [7:0]    mem_arr [0:255];
   logic [7:0]    ref_mem [0:255];

   int tests = 0;
   int fails = 0;

   mem_byte_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   // Environment memory: combinational read, write committed on the responding edge.
   assign mem_rdata = mem_arr[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_write && mem_resp) mem_arr[mem_addr[7:0]] <= mem_wdata;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode: 0 = always respond, 1 = stall 3 cycles on the second byte, 2 = random stalls
   task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int mode);
      logic [31:0] exp_addr [$];
      logic [7:0]  exp_byte [$];
      logic [31:0] exp_rdata;
      logic [31:0] a;
      logic [31:0] prev_addr;
      int n, c, stalls, got;
      logic done, stall, prev_stall;

      exp_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            a = addr + 32'(i);
            exp_addr.push_back(a);
            exp_byte.push_back(wd[8*i +: 8]);
            if (wr) ref_mem[a[7:0]] = wd[8*i +: 8];
            else    exp_rdata[8*i +: 8] = ref_mem[a[7:0]];
         end
      end
      n = exp_addr.size();

      chk("ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
      @(posedge clk);

      c = 0; stalls = 0; got = 0; done = 1'b0; prev_stall = 1'b0; prev_addr = '0;
      while (!done && c < 200) begin
         @(negedge clk);
         c++;
         if (c == 1) req_valid = 1'b0;
         chk("strobe_excl", 64'(mem_read & mem_write), 64'd0);
         if (mem_read || mem_write) begin
            if (prev_stall) chk("hold_addr", 64'(mem_addr), 64'(prev_addr));
            case (mode)
               1:       stall = (got == 1) && (stalls < 3);
               2:       stall = ($urandom_range(0, 3) == 0) && (stalls < 8);
               default: stall = 1'b0;
            endcase
            mem_resp = !stall;
            if (stall) begin
               stalls++;
            end else if (got < n) begin
               chk("addr", 64'(mem_addr), 64'(exp_addr[got]));
               chk("is_write", 64'(mem_write), 64'(wr));
               if (wr) chk("wdata", 64'(mem_wdata), 64'(exp_byte[got]));
               got++;
            end else begin
               chk("extra_access", 64'(got), 64'(n - 1));
            end
            prev_stall = stall;
            prev_addr  = mem_addr;
         end else begin
            mem_resp = 1'($urandom_range(0, 1));
            chk("idle_addr", 64'(mem_addr), 64'd0);
            chk("idle_wdata", 64'(mem_wdata), 64'd0);
         end
         if (rsp_valid) begin
            done = 1'b1;
            chk("latency", 64'(c), 64'(1 + n + stalls));
            chk("rdata", 64'(rsp_rdata), 64'(exp_rdata));
            chk("err", 64'(rsp_err), 64'd0);
            chk("ready_in_done", 64'(req_ready), 64'd0);
            chk("bytes_done", 64'(got), 64'(n));
            // A request offered during DONE must not be taken.
            req_valid = 1'b1; req_write = 1'b0; req_be = 4'hF;
         end
      end
      if (!done) chk("rsp_timeout", 64'd0, 64'd1);

      @(negedge clk);
      req_valid = 1'b0;
      chk("no_accept_in_done", 64'(mem_read | mem_write), 64'd0);
      chk("valid_one_cycle", 64'(rsp_valid), 64'd0);
      chk("ready_after", 64'(req_ready), 64'd1);
      chk("rdata_hold", 64'(rsp_rdata), 64'(exp_rdata));
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_be = '0; mem_resp = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 8'($urandom);
         ref_mem[i] = mem_arr[i];
      end
      mem_arr[8'h10] = 8'h11; mem_arr[8'h11] = 8'h22; mem_arr[8'h12] = 8'h33; mem_arr[8'h13] = 8'h44;
      ref_mem[8'h10] = 8'h11; ref_mem[8'h11] = 8'h22; ref_mem[8'h12] = 8'h33; ref_mem[8'h13] = 8'h44;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_err", 64'(rsp_err), 64'd0);
      chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_rst", 64'(req_ready), 64'd1);

      // Directed word load with known bytes
      run_req(1'b0, 32'h10, 32'h0, 4'hF, 0);
      chk("known_word", 64'(rsp_rdata), 64'h44332211);

      // Sparse store: lanes 0 and 2 only
      run_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
      chk("store_rdata_zero", 64'(rsp_rdata), 64'd0);

      // No lanes enabled
      run_req(1'b0, 32'h30, 32'h0, 4'h0, 0);

      // Address wrap at the top of the address space
      run_req(1'b0, 32'hFFFF_FFFE, 32'h0, 4'hF, 0);

      // Three-cycle stall on lane 1
      run_req(1'b0, 32'h40, 32'h0, 4'hF, 1);

      // Randomized traffic with random stalls
      for (int t = 0; t < 24; t++) begin
         run_req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 2);
      end

      // Reset during the second byte of a store
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h60; req_wdata = 32'h01020304; req_be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_b0_addr", 64'(mem_addr), 64'h60);
      mem_resp = 1'b1;
      ref_mem[8'h60] = 8'h04;
      @(negedge clk);
      chk("mid_b1_addr", 64'(mem_addr), 64'h61);
      mem_resp = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_strobes", 64'({mem_read, mem_write}), 64'd0);
      chk("mid_valid", 64'(rsp_valid), 64'd0);
      chk("mid_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_ready_after", 64'(req_ready), 64'd1);
      chk("mid_valid_after", 64'(rsp_valid), 64'd0);

      // Normal traffic resumes after reset
      run_req(1'b0, 32'h60, 32'h0, 4'hF, 0);

`ifdef MEM_BYTE_INITIATOR_TIMEOUT_EN
      begin
         int c;
         logic seen;
         req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h70; req_be = 4'hF;
         @(posedge clk);
         c = 0; seen = 1'b0;
         while (!seen && c < 200) begin
            @(negedge clk);
            c++;
            req_valid = 1'b0;
            mem_resp = 1'b0;
            if (rsp_valid) seen = 1'b1;
         end
         chk("to_seen", 64'(seen), 64'd1);
         chk("to_latency", 64'(c), 64'(TIMEOUT + 1));
         chk("to_err", 64'(rsp_err), 64'd1);
         chk("to_rdata", 64'(rsp_rdata), 64'd0);
         @(negedge clk);
      end
`endif

      // Memory contents versus the reference model
      for (int i = 0; i < 256; i++) begin
         chk("mem_final", 64'(mem_arr[i]), 64'(ref_mem[i]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
